// File: rtl/noc_pe_send_port_pkg.sv
// Shared widths, flit/credit field layout and FSM state type for the PE send port.
// Flit layout (MSB first): {valid, tail, dest, vc, data}; credit layout: {valid, vc}.
package noc_pe_pkg;
  localparam int NUM_VCS         = 2;
  localparam int NUM_RECV_PORTS  = 16;
  localparam int FLIT_DATA_WIDTH = 32;
  localparam int BUF_DEPTH       = 4;
  localparam int MAX_PKT_LEN     = 8;

  localparam int VC_BITS    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int DEST_BITS  = $clog2(NUM_RECV_PORTS);
  localparam int CNT_BITS   = $clog2(BUF_DEPTH + 1);
  localparam int LEN_BITS   = $clog2(MAX_PKT_LEN + 1);
  localparam int FLIT_WIDTH = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;

  localparam int FLIT_VC_LSB      = FLIT_DATA_WIDTH;
  localparam int FLIT_DEST_LSB    = FLIT_VC_LSB + VC_BITS;
  localparam int FLIT_TAIL_BIT    = FLIT_DEST_LSB + DEST_BITS;
  localparam int FLIT_VALID_BIT   = FLIT_TAIL_BIT + 1;
  localparam int CREDIT_WIDTH     = 1 + VC_BITS;
  localparam int CREDIT_VALID_BIT = VC_BITS;

  localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_PKT_LEN);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic                       valid;
    logic                       tail;
    logic [DEST_BITS-1:0]       dest;
    logic [VC_BITS-1:0]         vc;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } flit_t;

  // A zero length still carries one flit; oversize lengths are truncated.
  function automatic logic [LEN_BITS-1:0] clampLen(input logic [LEN_BITS-1:0] len);
    if (len == '0)
      return LEN_BITS'(1);
    else if (len > MAX_LEN_L)
      return MAX_LEN_L;
    else
      return len;
  endfunction
endpackage

// File: rtl/noc_pe_send_port_if.sv
// PE-side descriptor/payload handshakes plus the network putFlit/getCredits pair.
// master = PE core and network environment, slave = the send port.
interface noc_pe_send_port_if;
  import noc_pe_pkg::*;

  logic                       pkt_valid;
  logic                       pkt_ready;
  logic [DEST_BITS-1:0]       pkt_dest;
  logic [VC_BITS-1:0]         pkt_vc;
  logic [LEN_BITS-1:0]        pkt_len;
  logic                       data_valid;
  logic                       data_ready;
  logic [FLIT_DATA_WIDTH-1:0] data_in;
  logic [FLIT_WIDTH-1:0]      flit_out;
  logic                       sendFlit;
  logic [CREDIT_WIDTH-1:0]    credit_in;
  logic                       en_receiveCredit;

  modport master (
    output pkt_valid, pkt_dest, pkt_vc, pkt_len, data_valid, data_in, credit_in,
    input  pkt_ready, data_ready, flit_out, sendFlit, en_receiveCredit
  );

  modport slave (
    input  pkt_valid, pkt_dest, pkt_vc, pkt_len, data_valid, data_in, credit_in,
    output pkt_ready, data_ready, flit_out, sendFlit, en_receiveCredit
  );
endinterface

// File: rtl/noc_pe_send_port_credit_counter.sv
// One VC's credit counter: starts full, saturates on surplus credit and latches overflow.
// Simultaneous inc and dec cancel; dec is ignored at zero.
module noc_credit_counter #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         overflow
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= W'(DEPTH);
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == W'(DEPTH))
        overflow <= 1'b1;
      else
        cnt <= cnt + W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end
endmodule

// File: rtl/noc_pe_send_port.sv
// PE injection stage: segments descriptors into flits with per-VC credit flow control; 1-cycle payload-to-flit latency.
// Optional stat_flits/stat_pkts/stat_stall counters under NOC_PE_SEND_STATS_EN.
module noc_pe_send_port
  import noc_pe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  noc_pe_send_port_if.slave   port,
  output logic                busy,
  output logic                credit_err
`ifdef NOC_PE_SEND_STATS_EN
  ,
  output logic [31:0]         stat_flits,
  output logic [31:0]         stat_pkts,
  output logic [31:0]         stat_stall
`endif
);
  state_t               state;
  logic [DEST_BITS-1:0] destQ;
  logic [VC_BITS-1:0]   vcQ;
  logic [LEN_BITS-1:0]  rem;
  logic                 alive;
  flit_t                flitQ;
  logic                 sendQ;

  logic [CNT_BITS-1:0]  cnt [NUM_VCS];
  logic [NUM_VCS-1:0]   ovf;
  logic [NUM_VCS-1:0]   incVec;
  logic [NUM_VCS-1:0]   decVec;
  logic [VC_BITS-1:0]   creditVc;
  logic                 creditTake;
  logic                 pktFire;
  logic                 dataFire;

  // alive is low only until the first edge after reset release, gating credits and descriptors.
  assign creditVc        = port.credit_in[VC_BITS-1:0];
  assign creditTake      = port.credit_in[CREDIT_VALID_BIT] && alive;
  assign port.pkt_ready  = (state == IDLE) && alive;
  assign port.data_ready = (state == SEND) && (cnt[vcQ] != '0);
  assign pktFire         = port.pkt_valid && port.pkt_ready;
  assign dataFire        = port.data_valid && port.data_ready;

  assign port.flit_out         = flitQ;
  assign port.sendFlit         = sendQ;
  assign port.en_receiveCredit = alive;
  assign busy                  = (state == SEND);
  assign credit_err            = |ovf;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign incVec[v] = creditTake && (creditVc == VC_BITS'(v));
    assign decVec[v] = dataFire && (vcQ == VC_BITS'(v));

    noc_credit_counter #(
      .DEPTH (BUF_DEPTH),
      .W     (CNT_BITS)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (incVec[v]),
      .dec      (decVec[v]),
      .cnt      (cnt[v]),
      .overflow (ovf[v])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      destQ <= '0;
      vcQ   <= '0;
      rem   <= '0;
      alive <= 1'b0;
      flitQ <= '0;
      sendQ <= 1'b0;
    end else begin
      alive <= 1'b1;
      sendQ <= dataFire;
      // Header fields of the last flit are held; only the valid bit drops when idle.
      if (dataFire)
        flitQ <= '{valid: 1'b1, tail: (rem == LEN_BITS'(1)), dest: destQ, vc: vcQ, data: port.data_in};
      else
        flitQ.valid <= 1'b0;

      case (state)
        IDLE: begin
          if (pktFire) begin
            destQ <= port.pkt_dest;
            vcQ   <= port.pkt_vc;
            rem   <= clampLen(port.pkt_len);
            state <= SEND;
          end
        end
        SEND: begin
          if (dataFire) begin
            rem <= rem - LEN_BITS'(1);
            if (rem == LEN_BITS'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_PE_SEND_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits <= '0;
      stat_pkts  <= '0;
      stat_stall <= '0;
    end else begin
      if (dataFire)
        stat_flits <= stat_flits + 32'd1;
      if (dataFire && rem == LEN_BITS'(1))
        stat_pkts <= stat_pkts + 32'd1;
      if (state == SEND && port.data_valid && !port.data_ready)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_noc_pe_send_port.sv
// Directed bench for noc_pe_send_port: a packet/credit queue model checked every cycle,
// plus hand-computed flit literals for each scenario.
module tb_noc_pe_send_port;
  import noc_pe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_pe_send_port_if pif();
  logic busy;
  logic credit_err;
`ifdef NOC_PE_SEND_STATS_EN
  logic [31:0] stat_flits, stat_pkts, stat_stall;
`endif

  noc_pe_send_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .port       (pif),
    .busy       (busy),
    .credit_err (credit_err)
`ifdef NOC_PE_SEND_STATS_EN
    ,
    .stat_flits (stat_flits),
    .stat_pkts  (stat_pkts),
    .stat_stall (stat_stall)
`endif
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: pending flits of the current packet, credit per VC, sticky overflow.
  typedef struct {
    bit                   tail;
    logic [DEST_BITS-1:0] dest;
    logic [VC_BITS-1:0]   vc;
  } pend_t;

  pend_t                 pend[$];
  int                    mCnt [NUM_VCS];
  bit                    mErr, mAlive, expSend;
  logic [FLIT_WIDTH-1:0] expFlit;
  int                    mStall, mFlits, mTails;
  logic [FLIT_WIDTH-1:0] got[$];
  int                    gotCyc[$];
  int                    tailSeen = 0;
  int                    cyc = 0;

  always @(negedge clk) begin : mon
    bit expPr, expDr, dFire, pFire, cFire;
    int cv, n;
    cyc++;
    if (!rst_n) begin
      chk("rst_sendFlit", pif.sendFlit, 0);
      chk("rst_flit_out", pif.flit_out, 0);
      chk("rst_pkt_ready", pif.pkt_ready, 0);
      chk("rst_data_ready", pif.data_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_credit_err", credit_err, 0);
      chk("rst_en_receiveCredit", pif.en_receiveCredit, 0);
      pend.delete();
      foreach (mCnt[i]) mCnt[i] = BUF_DEPTH;
      mErr = 0; mAlive = 0; expSend = 0; expFlit = '0;
      mStall = 0; mFlits = 0; mTails = 0;
    end else begin
      expPr = mAlive && (pend.size() == 0);
      expDr = (pend.size() != 0) && (mCnt[pend[0].vc] != 0);
      chk("sendFlit", pif.sendFlit, expSend);
      chk("flit_out", pif.flit_out, expFlit);
      chk("pkt_ready", pif.pkt_ready, expPr);
      chk("data_ready", pif.data_ready, expDr);
      chk("busy", busy, pend.size() != 0);
      chk("credit_err", credit_err, mErr);
      chk("en_receiveCredit", pif.en_receiveCredit, mAlive);
      if (pif.sendFlit) begin
        got.push_back(pif.flit_out);
        gotCyc.push_back(cyc);
        if (pif.flit_out[FLIT_TAIL_BIT]) tailSeen++;
      end
      dFire = expDr && pif.data_valid;
      pFire = expPr && pif.pkt_valid;
      cFire = mAlive && pif.credit_in[CREDIT_VALID_BIT];
      if (pend.size() != 0 && pif.data_valid && !expDr) mStall++;
      if (dFire) begin
        expFlit = {1'b1, pend[0].tail, pend[0].dest, pend[0].vc, pif.data_in};
        expSend = 1;
        mCnt[pend[0].vc]--;
        mFlits++;
        if (pend[0].tail) mTails++;
        void'(pend.pop_front());
      end else begin
        expSend = 0;
        expFlit[FLIT_VALID_BIT] = 1'b0;
      end
      if (cFire) begin
        cv = int'(pif.credit_in[VC_BITS-1:0]);
        if (mCnt[cv] == BUF_DEPTH) mErr = 1;
        else mCnt[cv]++;
      end
      if (pFire) begin
        n = int'(pif.pkt_len);
        if (n == 0) n = 1;
        if (n > MAX_PKT_LEN) n = MAX_PKT_LEN;
        for (int k = 0; k < n; k++)
          pend.push_back('{tail: (k == n - 1), dest: pif.pkt_dest, vc: pif.pkt_vc});
      end
      mAlive = 1;
    end
  end

  // All drivers start and end at posedge+1.
  task automatic waitHs(input bit isData, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = isData ? pif.data_ready : pif.pkt_ready;
    end
    if (!ok) begin
      nChecks++;
      nErrors++;
      $display("FAIL %s_timeout: ready stayed 0 for 50 cycles, required 1", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic sendPkt(input logic [DEST_BITS-1:0] dest, input logic [VC_BITS-1:0] vc,
                         input logic [LEN_BITS-1:0] len);
    pif.pkt_valid = 1'b1;
    pif.pkt_dest  = dest;
    pif.pkt_vc    = vc;
    pif.pkt_len   = len;
    waitHs(0, "pkt");
    pif.pkt_valid = 1'b0;
  endtask

  task automatic sendData(input logic [FLIT_DATA_WIDTH-1:0] w);
    pif.data_valid = 1'b1;
    pif.data_in    = w;
    waitHs(1, "data");
  endtask

  task automatic credit(input logic [VC_BITS-1:0] vc);
    pif.credit_in = {1'b1, vc};
    @(posedge clk); #1;
    pif.credit_in = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // len=6 on vc0 from full credits: four flits, stall, one credit per remaining flit.
  task automatic scen2();
    sendPkt(4'd5, 1'b0, 4'd6);
    for (int i = 0; i < 4; i++) sendData(FLIT_DATA_WIDTH'(32'h20 + i));
    pif.data_in = 32'h24;
    repeat (3) @(negedge clk);
    chk("t2_stalled", pif.data_ready, 0);
    tick();
    pif.credit_in = {1'b1, 1'b0};
    @(negedge clk);
    chk("t2_no_bypass", pif.data_ready, 0);
    tick();
    pif.credit_in = '0;
    @(negedge clk);
    chk("t2_ready_rise", pif.data_ready, 1);
    tick();
    pif.data_in   = 32'h25;
    pif.credit_in = {1'b1, 1'b0};
    tick();
    pif.credit_in = '0;
    waitHs(1, "t2_last");
    pif.data_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int stall0, tails0;
    pif.pkt_valid  = 1'b0;
    pif.pkt_dest   = '0;
    pif.pkt_vc     = '0;
    pif.pkt_len    = '0;
    pif.data_valid = 1'b0;
    pif.data_in    = '0;
    pif.credit_in  = '0;

    repeat (3) @(posedge clk); #1;
    chk("rst_lit_sendFlit", pif.sendFlit, 0);
    rst_n = 1'b1;
    tick();
    chk("alive_pkt_ready", pif.pkt_ready, 1);
    chk("alive_en_receiveCredit", pif.en_receiveCredit, 1);

    // 1: three back-to-back flits on vc1
    got.delete(); gotCyc.delete();
    sendPkt(4'd10, 1'b1, 4'd3);
    sendData(32'hA); sendData(32'hB); sendData(32'hC);
    pif.data_valid = 1'b0;
    tick();
    chk("t1_count", got.size(), 3);
    chk("t1_f0", got[0], {1'b1, 1'b0, 4'd10, 1'b1, 32'hA});
    chk("t1_f1", got[1], {1'b1, 1'b0, 4'd10, 1'b1, 32'hB});
    chk("t1_f2", got[2], {1'b1, 1'b1, 4'd10, 1'b1, 32'hC});
    chk("t1_consecutive", gotCyc[2] - gotCyc[0], 2);
    chk("t1_model_cnt1", mCnt[1], 1);

    // 2: credit stall and single-credit resume
    got.delete();
    stall0 = mStall;
    scen2();
    tick();
    chk("t2_count", got.size(), 6);
    chk("t2_f4", got[4], {1'b1, 1'b0, 4'd5, 1'b0, 32'h24});
    chk("t2_f5", got[5], {1'b1, 1'b1, 4'd5, 1'b0, 32'h25});
    chk("t2_stall_cycles", mStall - stall0, 5);

    // 3: simultaneous send and credit on vc0 with two credits
    credit(1'b0); credit(1'b0);
    sendPkt(4'd3, 1'b0, 4'd2);
    pif.data_valid = 1'b1;
    pif.data_in    = 32'h30;
    pif.credit_in  = {1'b1, 1'b0};
    waitHs(1, "t3_d0");
    pif.credit_in = '0;
    chk("t3_model_cnt0", mCnt[0], 2);
    sendData(32'h31);
    pif.data_valid = 1'b0;
    sendPkt(4'd3, 1'b0, 4'd2);
    sendData(32'h32);
    pif.data_in = 32'h33;
    @(negedge clk);
    chk("t3_one_credit_left", pif.data_ready, 0);
    tick();
    credit(1'b0);
    waitHs(1, "t3_d3");
    pif.data_valid = 1'b0;

    // 4: overflow on vc1, sticky through traffic
    credit(1'b1); credit(1'b1); credit(1'b1);
    chk("t4_no_err_yet", credit_err, 0);
    credit(1'b1);
    chk("t4_err_set", credit_err, 1);
    chk("t4_model_cnt1", mCnt[1], 4);
    got.delete();
    sendPkt(4'd9, 1'b1, 4'd0);
    sendData(32'h40);
    pif.data_valid = 1'b0;
    tick();
    chk("t4_len0_single_tail", got[0], {1'b1, 1'b1, 4'd9, 1'b1, 32'h40});
    got.delete();
    sendPkt(4'd2, 1'b0, 4'd12);
    fork
      begin
        pif.credit_in = {1'b1, 1'b0};
        repeat (8) @(posedge clk);
        #1 pif.credit_in = '0;
      end
      begin
        for (int i = 0; i < 8; i++) sendData(FLIT_DATA_WIDTH'(32'h50 + i));
        pif.data_valid = 1'b0;
      end
    join
    repeat (2) tick();
    chk("t4_clamp_count", got.size(), 8);
    chk("t4_clamp_tail7", got[7][FLIT_TAIL_BIT], 1);
    chk("t4_clamp_tail6", got[6][FLIT_TAIL_BIT], 0);
    chk("t4_err_held", credit_err, 1);

    // 5: reset mid-packet after 2 of 5 flits
    repeat (4) credit(1'b0);
    tails0 = tailSeen;
    sendPkt(4'd7, 1'b0, 4'd5);
    sendData(32'h60); sendData(32'h61);
    chk("t5_sending", pif.sendFlit, 1);
    rst_n = 1'b0;
    pif.data_valid = 1'b0;
    #1;
    chk("t5_send_drop", pif.sendFlit, 0);
    chk("t5_flit_clear", pif.flit_out, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5_pkt_ready", pif.pkt_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_err_cleared", credit_err, 0);
    chk("t5_no_tail", tailSeen, tails0);

    // 6: scenario 2 again from fresh counters, then vc1 full-depth packet
    got.delete();
    scen2();
    chk("t6_model_stall", mStall, 5);
`ifdef NOC_PE_SEND_STATS_EN
    chk("t6_stat_flits", stat_flits, 6);
    chk("t6_stat_pkts", stat_pkts, 1);
    chk("t6_stat_stall", stat_stall, mStall);
`endif
    sendPkt(4'd15, 1'b1, 4'd4);
    for (int i = 0; i < 4; i++) sendData(FLIT_DATA_WIDTH'(32'h70 + i));
    pif.data_valid = 1'b0;
    tick();
    chk("t6_model_cnt1", mCnt[1], 0);

    tick();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
